// File: rtl/iq_issue.sv
// iq_issue: issue side of an issue queue. Holds entries written by the
// assigner, wakes sources on writeback broadcasts, selects one eligible
// entry per cycle into a valid/ready output register, and reports the
// freed entry index back to the assigner.
//
// Optional macro IQ_AGE_SELECT_EN: oldest-first select through an age
// matrix. Without it, the lowest-index eligible entry wins.
//
// Ports:
//   clk, reset_          clock, asynchronous active-low reset
//   flush                synchronous clear of entries and output register
//   alloc_*              entry write from the assigner
//   wb_valid, wb_sb_id   writeback wakeup broadcast
//   entry_busy           occupancy vector to the assigner
//   release_valid/idx    one-cycle pulse naming the freed entry
//   issue_valid/ready    handshake to the execution unit
//   issue_sb_id/idx      destination tag and source entry of the issue
`ifndef SbDepth
`define SbDepth 16
`endif

module iq_issue #(
   parameter  int unsigned IQ_DEPTH = 8,
   parameter  int unsigned SB_DEPTH = `SbDepth,
   localparam int unsigned IQ       = $clog2(IQ_DEPTH),
   localparam int unsigned SB       = $clog2(SB_DEPTH)
) (
   input  logic                clk,
   input  logic                reset_,
   input  logic                flush,
   input  logic                alloc_valid,
   input  logic [IQ-1:0]       alloc_idx,
   input  logic [SB-1:0]       alloc_sb_id,
   input  logic [SB-1:0]       alloc_src1_tag,
   input  logic [SB-1:0]       alloc_src2_tag,
   input  logic                alloc_src1_rdy,
   input  logic                alloc_src2_rdy,
   input  logic                wb_valid,
   input  logic [SB-1:0]       wb_sb_id,
   output logic [IQ_DEPTH-1:0] entry_busy,
   output logic                release_valid,
   output logic [IQ-1:0]       release_idx,
   output logic                issue_valid,
   input  logic                issue_ready,
   output logic [SB-1:0]       issue_sb_id,
   output logic [IQ-1:0]       issue_idx
);

   logic [IQ_DEPTH-1:0]         busy_q;
   logic [IQ_DEPTH-1:0]         src1_rdy_q;
   logic [IQ_DEPTH-1:0]         src2_rdy_q;
   logic [IQ_DEPTH-1:0][SB-1:0] src1_tag_q;
   logic [IQ_DEPTH-1:0][SB-1:0] src2_tag_q;
   logic [IQ_DEPTH-1:0][SB-1:0] sb_id_q;

   logic [IQ_DEPTH-1:0] eligible_c;
   logic [IQ_DEPTH-1:0] cand_c;
   logic [IQ_DEPTH-1:0] grant_c;
   logic [IQ-1:0]       sel_idx_c;
   logic                sel_valid_c;
   logic                out_free_c;
   logic                alloc_ok_c;

   assign entry_busy = busy_q;

   // Eligibility uses registered state only, so a wakeup or allocate
   // becomes selectable one cycle later.
   always_comb begin
      eligible_c  = busy_q & src1_rdy_q & src2_rdy_q;
      out_free_c  = !issue_valid || issue_ready;
      sel_valid_c = out_free_c && (|eligible_c);
      alloc_ok_c  = alloc_valid && !busy_q[alloc_idx];
   end

`ifdef IQ_AGE_SELECT_EN
   // age_q[j][i] set means entry j is older than entry i.
   logic [IQ_DEPTH-1:0][IQ_DEPTH-1:0] age_q;

   // Keep only eligible entries with no older eligible entry.
   always_comb begin
      cand_c = '0;
      for (int i = 0; i < int'(IQ_DEPTH); i++) begin
         logic older;
         older = 1'b0;
         for (int j = 0; j < int'(IQ_DEPTH); j++) begin
            if (eligible_c[j] && age_q[j][i]) older = 1'b1;
         end
         cand_c[i] = eligible_c[i] && !older;
      end
   end

   // New entry is younger than everything that stays resident.
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         age_q <= '0;
      end else if (flush) begin
         age_q <= '0;
      end else if (alloc_ok_c) begin
         for (int j = 0; j < int'(IQ_DEPTH); j++) begin
            age_q[alloc_idx][j] <= 1'b0;
            age_q[j][alloc_idx] <= busy_q[j] && !grant_c[j];
         end
      end
   end
`else
   always_comb cand_c = eligible_c;
`endif

   // Lowest-index candidate; with age select there is exactly one.
   always_comb begin
      sel_idx_c = '0;
      for (int i = int'(IQ_DEPTH) - 1; i >= 0; i--) begin
         if (cand_c[i]) sel_idx_c = IQ'(i);
      end
      grant_c = sel_valid_c ? (IQ_DEPTH'(1) << sel_idx_c) : '0;
   end

   // Entry storage: occupancy, tags, and source readiness with wakeup.
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         busy_q     <= '0;
         src1_rdy_q <= '0;
         src2_rdy_q <= '0;
         src1_tag_q <= '0;
         src2_tag_q <= '0;
         sb_id_q    <= '0;
      end else if (flush) begin
         busy_q     <= '0;
         src1_rdy_q <= '0;
         src2_rdy_q <= '0;
      end else begin
         for (int i = 0; i < int'(IQ_DEPTH); i++) begin
            if (busy_q[i] && wb_valid && (src1_tag_q[i] == wb_sb_id)) src1_rdy_q[i] <= 1'b1;
            if (busy_q[i] && wb_valid && (src2_tag_q[i] == wb_sb_id)) src2_rdy_q[i] <= 1'b1;
         end
         busy_q <= (busy_q & ~grant_c) | (alloc_ok_c ? (IQ_DEPTH'(1) << alloc_idx) : '0);
         if (alloc_ok_c) begin
            sb_id_q[alloc_idx]    <= alloc_sb_id;
            src1_tag_q[alloc_idx] <= alloc_src1_tag;
            src2_tag_q[alloc_idx] <= alloc_src2_tag;
            // Same-cycle writeback bypass into the new entry.
            src1_rdy_q[alloc_idx] <= alloc_src1_rdy || (wb_valid && (wb_sb_id == alloc_src1_tag));
            src2_rdy_q[alloc_idx] <= alloc_src2_rdy || (wb_valid && (wb_sb_id == alloc_src2_tag));
         end
      end
   end

   // Output register and release pulse.
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         issue_valid   <= 1'b0;
         issue_sb_id   <= '0;
         issue_idx     <= '0;
         release_valid <= 1'b0;
         release_idx   <= '0;
      end else if (flush) begin
         issue_valid   <= 1'b0;
         release_valid <= 1'b0;
      end else begin
         release_valid <= sel_valid_c;
         if (out_free_c) issue_valid <= sel_valid_c;
         if (sel_valid_c) begin
            release_idx <= sel_idx_c;
            issue_idx   <= sel_idx_c;
            issue_sb_id <= sb_id_q[sel_idx_c];
         end
      end
   end

   // Writing an occupied entry is a protocol error; the write is dropped.
   a_alloc_free: assert property (@(posedge clk) disable iff (!reset_)
      (alloc_valid && !flush) |-> !busy_q[alloc_idx]);

endmodule

// File: tb/tb_iq_issue.sv
// Directed self-checking bench for iq_issue (default 8 entries, 4-bit tags).
module tb_iq_issue;

   logic       clk = 1'b0;
   logic       reset_;
   logic       flush;
   logic       alloc_valid;
   logic [2:0] alloc_idx;
   logic [3:0] alloc_sb_id;
   logic [3:0] alloc_src1_tag;
   logic [3:0] alloc_src2_tag;
   logic       alloc_src1_rdy;
   logic       alloc_src2_rdy;
   logic       wb_valid;
   logic [3:0] wb_sb_id;
   logic [7:0] entry_busy;
   logic       release_valid;
   logic [2:0] release_idx;
   logic       issue_valid;
   logic       issue_ready;
   logic [3:0] issue_sb_id;
   logic [2:0] issue_idx;

   int tests = 0;
   int fails = 0;

   iq_issue dut (
      .clk(clk), .reset_(reset_), .flush(flush),
      .alloc_valid(alloc_valid), .alloc_idx(alloc_idx), .alloc_sb_id(alloc_sb_id),
      .alloc_src1_tag(alloc_src1_tag), .alloc_src2_tag(alloc_src2_tag),
      .alloc_src1_rdy(alloc_src1_rdy), .alloc_src2_rdy(alloc_src2_rdy),
      .wb_valid(wb_valid), .wb_sb_id(wb_sb_id),
      .entry_busy(entry_busy), .release_valid(release_valid), .release_idx(release_idx),
      .issue_valid(issue_valid), .issue_ready(issue_ready),
      .issue_sb_id(issue_sb_id), .issue_idx(issue_idx)
   );

   always #5 clk = ~clk;

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_alloc(input int idx, input int sb, input int t1, input bit r1,
                              input int t2, input bit r2);
      alloc_valid    = 1'b1;
      alloc_idx      = 3'(idx);
      alloc_sb_id    = 4'(sb);
      alloc_src1_tag = 4'(t1);
      alloc_src1_rdy = r1;
      alloc_src2_tag = 4'(t2);
      alloc_src2_rdy = r2;
   endtask

   task automatic idle_alloc();
      alloc_valid    = 1'b0;
      alloc_src1_rdy = 1'b0;
      alloc_src2_rdy = 1'b0;
   endtask

   task automatic test_reset();
      tests++; if (entry_busy !== 8'h00) begin fails++; $display("FAIL reset_busy got=%h exp=00", entry_busy); end
      tests++; if (issue_valid !== 1'b0) begin fails++; $display("FAIL reset_issue_valid got=%b exp=0", issue_valid); end
      tests++; if (release_valid !== 1'b0) begin fails++; $display("FAIL reset_release_valid got=%b exp=0", release_valid); end
      tests++; if ({issue_sb_id, issue_idx, release_idx} !== 10'h0) begin fails++;
         $display("FAIL reset_fields got sb=%0d idx=%0d rel=%0d exp=0", issue_sb_id, issue_idx, release_idx); end
   endtask

   task automatic test_single_issue();
      issue_ready = 1'b1;
      drive_alloc(3, 5, 0, 1'b1, 0, 1'b1);
      step(); idle_alloc();
      tests++; if (entry_busy !== 8'h08) begin fails++; $display("FAIL single_busy_t1 got=%h exp=08", entry_busy); end
      tests++; if (issue_valid !== 1'b0) begin fails++; $display("FAIL single_valid_t1 got=%b exp=0", issue_valid); end
      step();
      tests++; if ({issue_valid, issue_sb_id, issue_idx} !== {1'b1, 4'd5, 3'd3}) begin fails++;
         $display("FAIL single_issue got v=%b sb=%0d idx=%0d exp v=1 sb=5 idx=3", issue_valid, issue_sb_id, issue_idx); end
      tests++; if ({release_valid, release_idx} !== {1'b1, 3'd3}) begin fails++;
         $display("FAIL single_release got v=%b idx=%0d exp v=1 idx=3", release_valid, release_idx); end
      tests++; if (entry_busy !== 8'h00) begin fails++; $display("FAIL single_busy_t2 got=%h exp=00", entry_busy); end
      step();
      tests++; if ({issue_valid, release_valid} !== 2'b00) begin fails++;
         $display("FAIL single_drop got v=%b rel=%b exp 0 0", issue_valid, release_valid); end
   endtask

   task automatic test_wakeup();
      issue_ready = 1'b1;
      drive_alloc(0, 2, 7, 1'b0, 0, 1'b1);
      step(); idle_alloc();
      step(); step();
      wb_valid = 1'b1; wb_sb_id = 4'd7;
      step(); wb_valid = 1'b0;
      tests++; if (issue_valid !== 1'b0) begin fails++; $display("FAIL wake_early got=%b exp=0", issue_valid); end
      step();
      tests++; if ({issue_valid, issue_sb_id, issue_idx} !== {1'b1, 4'd2, 3'd0}) begin fails++;
         $display("FAIL wake_issue got v=%b sb=%0d idx=%0d exp v=1 sb=2 idx=0", issue_valid, issue_sb_id, issue_idx); end
      step();
      // Same-cycle allocate and writeback on the source tag.
      drive_alloc(1, 4, 7, 1'b0, 0, 1'b1);
      wb_valid = 1'b1; wb_sb_id = 4'd7;
      step(); idle_alloc(); wb_valid = 1'b0;
      tests++; if (issue_valid !== 1'b0) begin fails++; $display("FAIL bypass_early got=%b exp=0", issue_valid); end
      step();
      tests++; if ({issue_valid, issue_sb_id, issue_idx} !== {1'b1, 4'd4, 3'd1}) begin fails++;
         $display("FAIL bypass_issue got v=%b sb=%0d idx=%0d exp v=1 sb=4 idx=1", issue_valid, issue_sb_id, issue_idx); end
      step();
   endtask

   task automatic test_back_pressure();
      int rel_cnt;
      issue_ready = 1'b0;
      drive_alloc(2, 8, 0, 1'b1, 0, 1'b1);
      step();
      drive_alloc(4, 9, 0, 1'b1, 0, 1'b1);
      step(); idle_alloc();
      tests++; if ({issue_valid, issue_sb_id, issue_idx, release_valid, release_idx} !== {1'b1, 4'd8, 3'd2, 1'b1, 3'd2}) begin fails++;
         $display("FAIL bp_first got v=%b sb=%0d idx=%0d rel=%b ridx=%0d exp 1 8 2 1 2",
                  issue_valid, issue_sb_id, issue_idx, release_valid, release_idx); end
      rel_cnt = 0;
      for (int k = 0; k < 4; k++) begin
         step();
         if (release_valid) rel_cnt++;
         tests++; if ({issue_valid, issue_sb_id, issue_idx} !== {1'b1, 4'd8, 3'd2}) begin fails++;
            $display("FAIL bp_hold%0d got v=%b sb=%0d idx=%0d exp v=1 sb=8 idx=2", k, issue_valid, issue_sb_id, issue_idx); end
      end
      tests++; if (rel_cnt !== 0) begin fails++; $display("FAIL bp_extra_release got=%0d exp=0", rel_cnt); end
      tests++; if (entry_busy !== 8'h10) begin fails++; $display("FAIL bp_busy got=%h exp=10", entry_busy); end
      issue_ready = 1'b1;
      step();
      tests++; if ({issue_valid, issue_sb_id, issue_idx, release_valid, release_idx} !== {1'b1, 4'd9, 3'd4, 1'b1, 3'd4}) begin fails++;
         $display("FAIL bp_second got v=%b sb=%0d idx=%0d rel=%b ridx=%0d exp 1 9 4 1 4",
                  issue_valid, issue_sb_id, issue_idx, release_valid, release_idx); end
      step();
      tests++; if (issue_valid !== 1'b0) begin fails++; $display("FAIL bp_drop got=%b exp=0", issue_valid); end
   endtask

   task automatic test_priority();
      logic [2:0] first_idx, second_idx;
      logic [3:0] first_sb, second_sb;
`ifdef IQ_AGE_SELECT_EN
      first_idx = 3'd6; first_sb = 4'd10; second_idx = 3'd1; second_sb = 4'd11;
`else
      first_idx = 3'd1; first_sb = 4'd11; second_idx = 3'd6; second_sb = 4'd10;
`endif
      issue_ready = 1'b1;
      drive_alloc(6, 10, 3, 1'b0, 0, 1'b1);
      step();
      drive_alloc(1, 11, 3, 1'b0, 0, 1'b1);
      step(); idle_alloc();
      wb_valid = 1'b1; wb_sb_id = 4'd3;
      step(); wb_valid = 1'b0;
      tests++; if (issue_valid !== 1'b0) begin fails++; $display("FAIL prio_early got=%b exp=0", issue_valid); end
      step();
      tests++; if ({issue_sb_id, issue_idx, issue_valid} !== {first_sb, first_idx, 1'b1}) begin fails++;
         $display("FAIL prio_first got v=%b sb=%0d idx=%0d exp sb=%0d idx=%0d", issue_valid, issue_sb_id, issue_idx, first_sb, first_idx); end
      step();
      tests++; if ({issue_sb_id, issue_idx, issue_valid} !== {second_sb, second_idx, 1'b1}) begin fails++;
         $display("FAIL prio_second got v=%b sb=%0d idx=%0d exp sb=%0d idx=%0d", issue_valid, issue_sb_id, issue_idx, second_sb, second_idx); end
      step();
   endtask

   task automatic test_full_flush();
      int rel_cnt;
      issue_ready = 1'b1;
      rel_cnt = 0;
      for (int i = 0; i < 8; i++) begin
         drive_alloc(i, i, 15, 1'b0, 0, 1'b1);
         step();
         if (release_valid) rel_cnt++;
      end
      idle_alloc();
      tests++; if (entry_busy !== 8'hFF) begin fails++; $display("FAIL full_busy got=%h exp=FF", entry_busy); end
      tests++; if ({issue_valid, rel_cnt != 0} !== 2'b00) begin fails++;
         $display("FAIL full_no_issue got v=%b releases=%0d exp 0 0", issue_valid, rel_cnt); end
      flush = 1'b1;
      step(); flush = 1'b0;
      tests++; if ({entry_busy, issue_valid, release_valid} !== 10'h0) begin fails++;
         $display("FAIL flush_clear got busy=%h v=%b rel=%b exp 00 0 0", entry_busy, issue_valid, release_valid); end
      step();
      tests++; if ({issue_valid, release_valid} !== 2'b00) begin fails++;
         $display("FAIL flush_after got v=%b rel=%b exp 0 0", issue_valid, release_valid); end
   endtask

   task automatic test_flush_issue();
      issue_ready = 1'b0;
      drive_alloc(5, 12, 0, 1'b1, 0, 1'b1);
      step();
      drive_alloc(2, 13, 0, 1'b1, 0, 1'b1);
      step(); idle_alloc();
      tests++; if ({issue_valid, issue_idx} !== {1'b1, 3'd5}) begin fails++;
         $display("FAIL flushiss_pre got v=%b idx=%0d exp 1 5", issue_valid, issue_idx); end
      flush = 1'b1;
      step(); flush = 1'b0;
      tests++; if ({entry_busy, issue_valid, release_valid} !== 10'h0) begin fails++;
         $display("FAIL flushiss_clear got busy=%h v=%b rel=%b exp 00 0 0", entry_busy, issue_valid, release_valid); end
      step();
      tests++; if ({issue_valid, release_valid} !== 2'b00) begin fails++;
         $display("FAIL flushiss_after got v=%b rel=%b exp 0 0", issue_valid, release_valid); end
   endtask

   task automatic test_reset_mid();
      issue_ready = 1'b0;
      drive_alloc(3, 6, 0, 1'b1, 0, 1'b1);
      step(); idle_alloc();
      step();
      tests++; if ({issue_valid, issue_sb_id, issue_idx} !== {1'b1, 4'd6, 3'd3}) begin fails++;
         $display("FAIL rstmid_pre got v=%b sb=%0d idx=%0d exp 1 6 3", issue_valid, issue_sb_id, issue_idx); end
      #2 reset_ = 1'b0;
      #1;
      tests++; if ({entry_busy, issue_valid, issue_sb_id, issue_idx, release_valid, release_idx} !== 20'h0) begin fails++;
         $display("FAIL rstmid_clear got busy=%h v=%b sb=%0d idx=%0d rel=%b ridx=%0d exp all 0",
                  entry_busy, issue_valid, issue_sb_id, issue_idx, release_valid, release_idx); end
      @(negedge clk) reset_ = 1'b1;
      issue_ready = 1'b1;
      step();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      reset_ = 1'b0; flush = 1'b0; issue_ready = 1'b0;
      wb_valid = 1'b0; wb_sb_id = '0;
      alloc_idx = '0; alloc_sb_id = '0; alloc_src1_tag = '0; alloc_src2_tag = '0;
      idle_alloc();
      step(); step();
      test_reset();
      @(negedge clk) reset_ = 1'b1;
      step();
      test_single_issue();
      test_wakeup();
      test_back_pressure();
      test_priority();
      test_full_flush();
      test_flush_issue();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
